mem_port_arbiter: RTL
=====================

// Module: mem_port_arbiter
// PURPOSE
//  Two-requester round-robin arbiter/sequencer for the single DataMemory port.
//  Requester 0 = Cache miss/write-back path (cm_*). Requester 1 = a second master (DMA/boot loader).
//  Registers the granted request, drives the memory port, waits for ReadReady, returns data and a Done pulse.
//  Read timeout guards against a hung memory.
// PARAMETERS
//  ADDR_W    32   address width
//  DATA_W    32   data width
//  MAX_WAIT  64   cycles in RD before timeout (>=2)
// PORTS
//  CLK           in   1       clock, rising edge
//  Reset         in   1       asynchronous, active-low reset
//  rN_ReadValid  in   1       (N=0,1) read request, level, held until rN_Done
//  rN_WriteValid in   1       write request, level, held until rN_Done
//  rN_Addr       in   ADDR_W  request address, stable while request held
//  rN_WriteData  in   DATA_W  write data, stable while request held
//  rN_Done       out  1       one-cycle completion pulse to requester N
//  rN_ReadData   out  DATA_W  read result, valid when rN_Done=1
//  rN_Error      out  1       with rN_Done: read timed out
//  m_ReadValid   out  1       to DataMemory ReadValid
//  m_WriteValid  out  1       to DataMemory WriteValid
//  m_ReadAddr    out  ADDR_W  to DataMemory ReadAddr
//  m_WriteAddr   out  ADDR_W  to DataMemory WriteAddr
//  m_WriteData   out  DATA_W  to DataMemory WriteData
//  m_ReadReady   in   1       from DataMemory ReadReady
//  m_ReadData    in   DATA_W  from DataMemory ReadData, valid with m_ReadReady
// BEHAVIOUR
//  - Reset low (any time, mid-op included): state=IDLE, all outputs 0, last_grant=1, wait_cnt=0.
//    Transactions in flight are dropped; no Done is issued.
//  - States: IDLE, WR, RD, RESP.
//  - IDLE, arbitration:
//      only one requester active -> grant it
//      both active -> grant the one != last_grant (first grant after reset = r0)
//    On grant, latch the following and update last_grant:
//      grant id, op (WriteValid has priority if both set), Addr, WriteData
//  - IDLE->WR (write grant):
//      WR lasts exactly 1 cycle: m_WriteValid=1, m_WriteAddr/m_WriteData=latched, rN_Done=1
//      then IDLE. Write latency: request seen at edge k -> Done at cycle k+1.
//  - IDLE->RD (read grant):
//      m_ReadValid=1, m_ReadAddr=latched, held every RD cycle; wait_cnt increments per RD cycle.
//      m_ReadReady=1 in RD -> capture m_ReadData into rN_ReadData, Error=0, ->RESP.
//      wait_cnt==MAX_WAIT-1 without ReadReady -> rN_ReadData=0, Error=1, ->RESP.
//      ReadReady on the timeout cycle counts as success.
//  - RESP: 1 cycle, rN_Done=1 for granted N (Error as captured), m_ReadValid=0, ->IDLE, wait_cnt=0.
//  - rN_ReadData/rN_Error hold their value until the next read completion for N.
//    Both are 0 after reset.
//  - m_ReadReady outside RD is ignored. Only one rN_Done is high in any cycle.
//  - Back-to-back: IDLE occupies 1 cycle between transactions.
//    A requester must deassert after its Done, else it is re-arbitrated.
//    Round-robin still lets the other requester in first.
//  - m_* address/data outputs are 0 in IDLE; Done/Valid outputs are decoded from registered state only.
// TESTING
//  - Reset mid-RD:
//      r0 read 0x40, pull Reset low while m_ReadValid=1
//      -> all outputs 0 immediately (async)
//      -> after release, IDLE; r0 re-request served normally
//  - Single write:
//      r1 write Addr=0x10 Data=0xDEADBEEF
//      -> next cycle m_WriteValid=1, m_WriteAddr=0x10, m_WriteData=0xDEADBEEF, r1_Done=1, one cycle only
//  - Read, 3-cycle memory:
//      r0 read 0x20, memory returns 0x12345678 on 3rd RD cycle
//      -> r0_Done next cycle, r0_ReadData=0x12345678, r0_Error=0
//  - Contention:
//      r0 and r1 both hold reads from reset
//      -> grant order r0, r1, r0, r1
//      -> no cycle with both Done high
//  - Timeout:
//      r1 read, m_ReadReady never asserted, MAX_WAIT=64
//      -> r1_Done, r1_Error=1, r1_ReadData=0 one cycle after the 64th RD cycle
//  - Ready at boundary:
//      m_ReadReady asserted exactly on the 64th RD cycle
//      -> Error=0, data captured

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter between the cache-miss path (r0) and a second master
// (r1) for the single DataMemory port. Latches one request at a time, drives
// the memory port, and returns read data, an error flag and a Done pulse.
//
// state | meaning
// IDLE  | no transaction; arbitrate and latch the winner
// WR    | one-cycle memory write, Done to the granted requester
// RD    | hold memory read until ReadReady or timeout
// RESP  | one-cycle Done for a finished read (data/error already captured)
module mem_port_arbiter #(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int MAX_WAIT = 64
) (
    input  logic              CLK,
    input  logic              Reset,
    input  logic              r0_ReadValid,
    input  logic              r0_WriteValid,
    input  logic [ADDR_W-1:0] r0_Addr,
    input  logic [DATA_W-1:0] r0_WriteData,
    output logic              r0_Done,
    output logic [DATA_W-1:0] r0_ReadData,
    output logic              r0_Error,
    input  logic              r1_ReadValid,
    input  logic              r1_WriteValid,
    input  logic [ADDR_W-1:0] r1_Addr,
    input  logic [DATA_W-1:0] r1_WriteData,
    output logic              r1_Done,
    output logic [DATA_W-1:0] r1_ReadData,
    output logic              r1_Error,
    output logic              m_ReadValid,
    output logic              m_WriteValid,
    output logic [ADDR_W-1:0] m_ReadAddr,
    output logic [ADDR_W-1:0] m_WriteAddr,
    output logic [DATA_W-1:0] m_WriteData,
    input  logic              m_ReadReady,
    input  logic [DATA_W-1:0] m_ReadData
);

    localparam int WAIT_W = (MAX_WAIT > 2) ? $clog2(MAX_WAIT) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MAX_WAIT - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WR   = 2'd1,
        RD   = 2'd2,
        RESP = 2'd3
    } state_t;

    state_t              state;
    state_t              stateNext;
    logic                lastGrant;
    logic                grantId;
    logic [ADDR_W-1:0]   addrQ;
    logic [DATA_W-1:0]   wdataQ;
    logic [WAIT_W-1:0]   waitCnt;
    logic [DATA_W-1:0]   rdData0;
    logic [DATA_W-1:0]   rdData1;
    logic                rdErr0;
    logic                rdErr1;

    logic                r0Active;
    logic                r1Active;
    logic                grantValid;
    logic                grantSel;
    logic                grantWrite;
    logic                rdFinish;

    // Arbitration: a lone requester wins; on contention the one not served last wins.
    always_comb begin
        r0Active   = r0_ReadValid | r0_WriteValid;
        r1Active   = r1_ReadValid | r1_WriteValid;
        grantValid = r0Active | r1Active;
        if (r0Active && r1Active) begin
            grantSel = ~lastGrant;
        end else begin
            grantSel = r1Active;
        end
        grantWrite = grantSel ? r1_WriteValid : r0_WriteValid;
    end

    // Next-state and output decode; Done/Valid come only from the registered state.
    always_comb begin
        stateNext    = state;
        rdFinish     = 1'b0;
        m_ReadValid  = 1'b0;
        m_WriteValid = 1'b0;
        m_ReadAddr   = '0;
        m_WriteAddr  = '0;
        m_WriteData  = '0;
        r0_Done      = 1'b0;
        r1_Done      = 1'b0;
        case (state)
            IDLE: begin
                if (grantValid) begin
                    stateNext = grantWrite ? WR : RD;
                end
            end
            WR: begin
                m_WriteValid = 1'b1;
                m_WriteAddr  = addrQ;
                m_WriteData  = wdataQ;
                r0_Done      = ~grantId;
                r1_Done      = grantId;
                stateNext    = IDLE;
            end
            RD: begin
                m_ReadValid = 1'b1;
                m_ReadAddr  = addrQ;
                if (m_ReadReady || (waitCnt == WAIT_LAST)) begin
                    rdFinish  = 1'b1;
                    stateNext = RESP;
                end
            end
            RESP: begin
                r0_Done   = ~grantId;
                r1_Done   = grantId;
                stateNext = IDLE;
            end
            default: stateNext = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    // Latch the granted request and run the read wait counter.
    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            lastGrant <= 1'b1;
            grantId   <= 1'b0;
            addrQ     <= '0;
            wdataQ    <= '0;
            waitCnt   <= '0;
        end else begin
            if (state == IDLE && grantValid) begin
                lastGrant <= grantSel;
                grantId   <= grantSel;
                addrQ     <= grantSel ? r1_Addr : r0_Addr;
                wdataQ    <= grantSel ? r1_WriteData : r0_WriteData;
            end
            if (state == RD && !rdFinish) begin
                waitCnt <= waitCnt + WAIT_W'(1);
            end else begin
                waitCnt <= '0;
            end
        end
    end

    // Capture read result for the granted requester; a timeout returns zero data.
    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            rdData0 <= '0;
            rdData1 <= '0;
            rdErr0  <= 1'b0;
            rdErr1  <= 1'b0;
        end else if (rdFinish) begin
            if (grantId) begin
                rdData1 <= m_ReadReady ? m_ReadData : '0;
                rdErr1  <= ~m_ReadReady;
            end else begin
                rdData0 <= m_ReadReady ? m_ReadData : '0;
                rdErr0  <= ~m_ReadReady;
            end
        end
    end

    assign r0_ReadData = rdData0;
    assign r1_ReadData = rdData1;
    assign r0_Error    = rdErr0;
    assign r1_Error    = rdErr1;

endmodule
